// File: rtl/descrambler_64b_if.sv
// Bus bundle between the 64b/66b descrambler and its upstream/downstream logic.
// The master drives the scrambled words and err_clr; the slave returns the recovered payload and checker status.
interface descrambler_64b_if #(
    parameter int ERR_W = 16
) ();
    logic             in_valid;
    logic [63:0]      in_data;
    logic             err_clr;
    logic             out_valid;
    logic [63:0]      out_data;
    logic             out_locked;
    logic             chk_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output in_valid, in_data, err_clr,
        input  out_valid, out_data, out_locked, chk_err, err_cnt
    );

    modport slave (
        input  in_valid, in_data, err_clr,
        output out_valid, out_data, out_locked, chk_err, err_cnt
    );
endinterface

// File: rtl/descrambler_64b.sv
// Self-synchronising x^58+x^39+1 descrambler for 64b/66b payload words, with a
// counter-pattern checker that tracks lock and counts mismatching words.
module descrambler_64b #(
    parameter int CHECK_EN  = 1,
    parameter int BAD_LIMIT = 4,
    parameter int ERR_W     = 16
) (
    input  logic              CLK,
    input  logic              reset,
    descrambler_64b_if.slave  bus
);

    localparam logic [1:0]       ST_WARM   = 2'd0;
    localparam logic [1:0]       ST_SEED   = 2'd1;
    localparam logic [1:0]       ST_CHECK  = 2'd2;
    localparam logic [3:0]       BAD_LIM_C = 4'(BAD_LIMIT);
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

    // Bit 0 of each word is the oldest; bits 0..57 of ext are the previous 58 received bits.
    function automatic logic [63:0] descramble(input logic [57:0] h, input logic [63:0] w);
        logic [121:0] ext;
        logic [63:0]  d;
        ext = {w, h};
        for (int i = 0; i < 64; i++) begin
            d[i] = ext[i+58] ^ ext[i+19] ^ ext[i];
        end
        return d;
    endfunction

    logic [57:0]      hist_q,       hist_d;
    logic [63:0]      exp_q,        exp_d;
    logic [3:0]       bad_q,        bad_d;
    logic [1:0]       state_q,      state_d;
    logic             out_valid_q,  out_valid_d;
    logic [63:0]      out_data_q,   out_data_d;
    logic             out_locked_q, out_locked_d;
    logic             chk_err_q,    chk_err_d;
    logic [ERR_W-1:0] err_cnt_q,    err_cnt_d;

    logic [63:0]      descr_s;
    logic             mismatch_s;
    logic             err_inc_s;
    logic [3:0]       bad_inc_s;

    // Next-state logic: datapath, lock FSM and error counter.
    always_comb begin
        descr_s      = descramble(hist_q, bus.in_data);
        mismatch_s   = (CHECK_EN != 0) && (descr_s != exp_q);
        bad_inc_s    = bad_q + 4'd1;
        hist_d       = hist_q;
        exp_d        = exp_q;
        bad_d        = bad_q;
        state_d      = state_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_locked_d = out_locked_q;
        chk_err_d    = 1'b0;
        err_inc_s    = 1'b0;

        if (bus.in_valid) begin
            hist_d      = bus.in_data[63:6];
            out_valid_d = 1'b1;
            out_data_d  = descr_s;
            case (state_q)
                ST_WARM: begin
                    out_locked_d = 1'b0;
                    state_d      = ST_SEED;
                end
                ST_SEED: begin
                    exp_d        = descr_s + 64'd1;
                    bad_d        = 4'd0;
                    out_locked_d = 1'b1;
                    state_d      = ST_CHECK;
                end
                ST_CHECK: begin
                    // Expectation always advances on its own so a corrupt word never seeds it.
                    exp_d = exp_q + 64'd1;
                    if (mismatch_s) begin
                        chk_err_d = 1'b1;
                        err_inc_s = 1'b1;
                        bad_d     = bad_inc_s;
                        if (bad_inc_s == BAD_LIM_C) begin
                            out_locked_d = 1'b0;
                            state_d      = ST_SEED;
                        end else begin
                            out_locked_d = 1'b1;
                        end
                    end else begin
                        bad_d        = 4'd0;
                        out_locked_d = 1'b1;
                    end
                end
                default: begin
                    out_locked_d = 1'b0;
                    state_d      = ST_WARM;
                end
            endcase
        end else begin
            out_valid_d = 1'b0;
        end

        if (bus.err_clr) begin
            err_cnt_d = '0;
        end else if (err_inc_s && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            hist_q       <= 58'd0;
            exp_q        <= 64'd0;
            bad_q        <= 4'd0;
            state_q      <= ST_WARM;
            out_valid_q  <= 1'b0;
            out_data_q   <= 64'd0;
            out_locked_q <= 1'b0;
            chk_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            hist_q       <= hist_d;
            exp_q        <= exp_d;
            bad_q        <= bad_d;
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_locked_q <= out_locked_d;
            chk_err_q    <= chk_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_locked = out_locked_q;
    assign bus.chk_err    = chk_err_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_descrambler_64b.sv
// Directed bench for descrambler_64b: a bench-side scrambler feeds the DUT and a
// per-cycle scoreboard of expected outputs is compared as each output cycle appears.
module tb_descrambler_64b;

    localparam int LIMIT = 4;

    logic CLK;
    logic reset;

    descrambler_64b_if #(.ERR_W(16)) bus ();

    descrambler_64b #(.CHECK_EN(1), .BAD_LIMIT(LIMIT), .ERR_W(16)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        v;
        logic [63:0] d;
        logic        l;
        logic        c;
        logic [15:0] e;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [57:0] sh;
    logic [57:0] m_hist;
    logic [63:0] m_exp;
    int          m_bad;
    int          m_state;
    logic [63:0] m_data;
    logic        m_locked;
    logic [15:0] m_err;

    function automatic logic [63:0] scr(input logic [57:0] h, input logic [63:0] p);
        logic [121:0] e;
        e = {64'd0, h};
        for (int i = 0; i < 64; i++) e[i+58] = p[i] ^ e[i+19] ^ e[i];
        return e[121:58];
    endfunction

    function automatic logic [63:0] dscr(input logic [57:0] h, input logic [63:0] w);
        logic [121:0] e;
        logic [63:0]  d;
        e = {w, h};
        for (int i = 0; i < 64; i++) d[i] = e[i+58] ^ e[i+19] ^ e[i];
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    endtask

    task automatic model_reset();
        m_hist = 58'd0; m_exp = 64'd0; m_bad = 0; m_state = 0;
        m_data = 64'd0; m_locked = 1'b0; m_err = 16'd0;
        sb.delete();
    endtask

    // one clock: drive inputs, predict, then compare at the following negedge
    task automatic drive(input logic v, input logic [63:0] w, input logic clr);
        exp_t        x;
        logic [63:0] d;
        logic        inc;
        inc = 1'b0;
        x.c = 1'b0;
        if (v) begin
            d = dscr(m_hist, w);
            m_hist = w[63:6];
            m_data = d;
            if (m_state == 0) begin
                m_locked = 1'b0; m_state = 1;
            end else if (m_state == 1) begin
                m_exp = d + 64'd1; m_bad = 0; m_locked = 1'b1; m_state = 2;
            end else begin
                if (d == m_exp) begin
                    m_bad = 0;
                end else begin
                    x.c = 1'b1; inc = 1'b1; m_bad++;
                    if (m_bad == LIMIT) begin
                        m_locked = 1'b0; m_state = 1;
                    end
                end
                m_exp = m_exp + 64'd1;
            end
        end
        if (clr) m_err = 16'd0;
        else if (inc && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        x.v = v; x.d = m_data; x.l = m_locked; x.e = m_err;
        sb.push_back(x);

        bus.in_valid = v;
        bus.in_data  = w;
        bus.err_clr  = clr;
        @(posedge CLK);
        @(negedge CLK);
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
        end else begin
            x = sb.pop_front();
            chk("out_valid",  {63'd0, bus.out_valid},  {63'd0, x.v});
            chk("out_data",   bus.out_data,            x.d);
            chk("out_locked", {63'd0, bus.out_locked}, {63'd0, x.l});
            chk("chk_err",    {63'd0, bus.chk_err},    {63'd0, x.c});
            chk("err_cnt",    {48'd0, bus.err_cnt},    {48'd0, x.e});
        end
    endtask

    task automatic send(input logic [63:0] p, input int gap, input logic clr);
        logic [63:0] s;
        s  = scr(sh, p);
        sh = s[63:6];
        drive(1'b1, s, clr);
        for (int g = 0; g < gap; g++) drive(1'b0, {$urandom, $urandom}, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},  {63'd0, bus.out_valid},  64'd0);
        chk({tag, "_data"},   bus.out_data,            64'd0);
        chk({tag, "_locked"}, {63'd0, bus.out_locked}, 64'd0);
        chk({tag, "_chk"},    {63'd0, bus.chk_err},    64'd0);
        chk({tag, "_cnt"},    {48'd0, bus.err_cnt},    64'd0);
    endtask

    // asynchronous reset pulse started away from any clock edge
    task automatic do_reset(input string tag);
        #2;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check_zero({tag, "_hold"});
        reset = 1'b1;
    endtask

    logic [63:0] cnt;
    logic [15:0] err_before;
    logic [63:0] s20;

    initial begin
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 64'd0;
        bus.err_clr  = 1'b0;
        model_reset();
        #12;
        check_zero("por");
        @(negedge CLK);
        reset = 1'b1;

        // 1: all-zero words; third word already compared against the seeded count
        for (int i = 0; i < 3; i++) drive(1'b1, 64'd0, 1'b0);

        // 2: clean counter 0..99 from a zero scrambler history
        do_reset("rst2");
        sh = 58'd0;
        for (int i = 0; i < 100; i++) begin
            send(64'(i), 0, 1'b0);
            if (i >= 1) chk("t2_locked", {63'd0, bus.out_locked}, 64'd1);
            chk("t2_counter", bus.out_data, 64'(i));
        end
        chk("t2_err_cnt", {48'd0, bus.err_cnt}, 64'd0);

        // 3: same stream, bit 10 of word 20 flipped on the line
        do_reset("rst3");
        sh = 58'd0;
        for (int i = 0; i < 100; i++) begin
            if (i == 20) begin
                s20 = scr(sh, 64'd20);
                sh  = s20[63:6];
                s20[10] = ~s20[10];
                drive(1'b1, s20, 1'b0);
            end else begin
                send(64'(i), 0, 1'b0);
            end
            if (i == 20 || i == 21) chk("t3_chk_err", {63'd0, bus.chk_err}, 64'd1);
            if (i >= 1) chk("t3_locked", {63'd0, bus.out_locked}, 64'd1);
        end
        chk("t3_err_cnt", {48'd0, bus.err_cnt}, 64'd2);

        // 4: counter across the 64-bit wrap with 0..3 idle cycles between words
        do_reset("rst4");
        sh  = 58'd0;
        cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        for (int i = 0; i < 10; i++) begin
            send(cnt, i % 4, 1'b0);
            cnt = cnt + 64'd1;
        end
        chk("t4_err_cnt", {48'd0, bus.err_cnt}, 64'd0);

        // 5: four foreign words in CHECK force loss of lock, then the counter resumes
        err_before = bus.err_cnt;
        for (int i = 0; i < 4; i++) begin
            send({$urandom, $urandom}, 0, 1'b0);
            cnt = cnt + 64'd1;
        end
        chk("t5_unlock", {63'd0, bus.out_locked}, 64'd0);
        send(cnt, 0, 1'b0);
        cnt = cnt + 64'd1;
        chk("t5_reseed_lock", {63'd0, bus.out_locked}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            send(cnt, 0, 1'b0);
            cnt = cnt + 64'd1;
        end
        n_checks++;
        assert ((bus.err_cnt - err_before) >= 16'd4 && (bus.err_cnt - err_before) <= 16'd5) n_pass++;
        else $error("FAIL t5_err_delta: observed=%0d expected=4..5", bus.err_cnt - err_before);

        // 6: reset mid-stream, resume with the scrambler history intact
        do_reset("rst6");
        for (int i = 0; i < 4; i++) begin
            send(cnt, 0, 1'b0);
            if (i == 0) chk("t6_warm", {63'd0, bus.out_locked}, 64'd0);
            if (i >= 1) chk("t6_locked", {63'd0, bus.out_locked}, 64'd1);
            cnt = cnt + 64'd1;
        end
        chk("t6_err_cnt", {48'd0, bus.err_cnt}, 64'd0);
        send(cnt + 64'd100, 0, 1'b0);
        cnt = cnt + 64'd1;
        chk("t6_err_one", {48'd0, bus.err_cnt}, 64'd1);
        send(cnt + 64'd100, 0, 1'b1);
        cnt = cnt + 64'd1;
        chk("t6_clr_pulse", {63'd0, bus.chk_err}, 64'd1);
        chk("t6_clr_cnt", {48'd0, bus.err_cnt}, 64'd0);
        send(cnt, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
